psec6_spi_host: RTL

SPI controller that drives the PSEC6 chip's serial configuration port from the test-board or on-chip sequencer side. It accepts one register command at a time over a start/busy/done handshake and serialises it onto `spi_clk_out`/`pico`/`cs`. It captures `poci` for reads and returns the byte on `rdata`. Each command is exactly one two-byte frame framed by one `cs` assertion, matching the chip-side frame format.

---
 rtl/psec6_spi_host_if.sv | 21 ++
 rtl/psec6_spi_host.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/psec6_spi_host_if.sv
// Command-side handshake bundle for the PSEC6 SPI host: one register command
// in (start/is_write/addr/wdata), status and read data out (busy/done/rdata).
interface psec6_spi_host_if;
  logic       start;
  logic       is_write;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output start, is_write, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, is_write, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/psec6_spi_host.sv
// SPI host for the PSEC6 configuration port: one 16-bit frame per command,
// {is_write, addr} then wdata (or 8'h00 for reads), MSB first, read byte on rdata.
module psec6_spi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rstn,
  psec6_spi_host_if.slave    cmd,
  output logic               spi_clk_out,
  output logic               pico,
  output logic               cs,
  input  logic               poci
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [15:0]   tx, tx_n;
  logic [7:0]    rx, rx_n;
  logic          wr_lat, wr_n;
  logic          sclk, sclk_n;
  logic          cs_q, cs_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [7:0]    rdata_q, rdata_n;
  logic          tick;
  logic          accept;

  assign tick = (div_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      div_cnt <= DIV_RELOAD;
      bit_cnt <= 4'd0;
      tx      <= 16'h0000;
      rx      <= 8'h00;
      wr_lat  <= 1'b0;
      sclk    <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      tx      <= tx_n;
      rx      <= rx_n;
      wr_lat  <= wr_n;
      sclk    <= sclk_n;
      cs_q    <= cs_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      rdata_q <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    tx_n    = tx;
    rx_n    = rx;
    wr_n    = wr_lat;
    sclk_n  = sclk;
    cs_n    = cs_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    rdata_n = rdata_q;
    accept  = 1'b0;

    if (state != IDLE) begin
      div_n = tick ? DIV_RELOAD : div_cnt - DW'(1);
    end

    case (state)
      IDLE: begin
        accept = cmd.start;
      end
      SETUP: begin
        if (tick) begin
          sclk_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk) begin
            sclk_n = 1'b1;
            // Only the second byte of the frame carries read data.
            if (bit_cnt[3]) begin
              rx_n = {rx[6:0], poci};
            end
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_n = HOLD;
            end else begin
              bit_n = bit_cnt + 4'd1;
              tx_n  = {tx[14:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n    = 1'b1;
          tx_n    = 16'h0000;
          state_n = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
          if (!wr_lat) begin
            rdata_n = rx;
          end
          // A start seen on the done edge chains straight into the next frame.
          accept = cmd.start;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (accept) begin
      state_n = SETUP;
      div_n   = DIV_RELOAD;
      bit_n   = 4'd0;
      tx_n    = {cmd.is_write, cmd.addr, cmd.is_write ? cmd.wdata : 8'h00};
      rx_n    = 8'h00;
      wr_n    = cmd.is_write;
      sclk_n  = 1'b0;
      cs_n    = 1'b0;
      busy_n  = 1'b1;
    end
  end

  assign spi_clk_out = sclk;
  assign pico        = tx[15];
  assign cs          = cs_q;
  assign cmd.busy    = busy_q;
  assign cmd.done    = done_q;
  assign cmd.rdata   = rdata_q;

endmodule
